// File: rtl/invader_step_scheduler.sv
// Alien formation step scheduler: divides frame ticks into step/drop pulses,
// tracks march direction and shortens the step period as the speed level rises.
module invader_step_scheduler #(
    parameter int PERIOD_W    = 8,
    parameter int BASE_PERIOD = 60,
    parameter int PERIOD_DEC  = 4,
    parameter int MIN_PERIOD  = 2,
    parameter int LEVEL_W     = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               speed_up,
    input  logic               edge_hit,
    output logic               step,
    output logic               drop,
    output logic               dir,
    output logic [LEVEL_W-1:0] level,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam int PROD_W = PERIOD_W + LEVEL_W;
    localparam logic [PERIOD_W-1:0] BASE_LAST = PERIOD_W'(BASE_PERIOD - 1);

    // Step period for a level, floored at MIN_PERIOD without ever wrapping.
    function automatic logic [PERIOD_W-1:0] period_of(input logic [LEVEL_W-1:0] lvl);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(lvl) * PROD_W'(PERIOD_DEC);
        if (prod > PROD_W'(BASE_PERIOD - MIN_PERIOD))
            return PERIOD_W'(MIN_PERIOD);
        else
            return PERIOD_W'(BASE_PERIOD) - prod[PERIOD_W-1:0];
    endfunction

    function automatic logic [LEVEL_W-1:0] level_sat_inc(input logic [LEVEL_W-1:0] lvl);
        if (lvl == {LEVEL_W{1'b1}})
            return lvl;
        else
            return lvl + LEVEL_W'(1);
    endfunction

    state_t              state;
    state_t              state_nxt;
    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] count_nxt;
    logic [LEVEL_W-1:0]  level_nxt;
    logic                dir_nxt;
    logic                just_dropped;
    logic                just_dropped_nxt;
    logic                step_nxt;
    logic                drop_nxt;
    logic                advance;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop)
            state_nxt = IDLE;
        else if (start)
            state_nxt = RUN;
        else begin
            case (state)
                RUN:     if (pause)  state_nxt = PAUSED;
                PAUSED:  if (!pause) state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE);
        advance = (state == RUN) && frame_tick && !pause && !start && !stop;
    end

    // A reload always uses the level held before any same-cycle speed_up.
    always_comb begin
        count_nxt        = count;
        level_nxt        = level;
        dir_nxt          = dir;
        just_dropped_nxt = just_dropped;
        step_nxt         = 1'b0;
        drop_nxt         = 1'b0;
        if (stop) begin
            count_nxt = count;
        end else if (start) begin
            count_nxt        = BASE_LAST;
            level_nxt        = '0;
            dir_nxt          = 1'b1;
            just_dropped_nxt = 1'b0;
        end else begin
            if (speed_up && (state == RUN || state == PAUSED))
                level_nxt = level_sat_inc(level);
            if (advance) begin
                if (count == '0) begin
                    count_nxt = period_of(level) - PERIOD_W'(1);
                    if (edge_hit && !just_dropped) begin
                        drop_nxt         = 1'b1;
                        dir_nxt          = !dir;
                        just_dropped_nxt = 1'b1;
                    end else begin
                        step_nxt         = 1'b1;
                        just_dropped_nxt = 1'b0;
                    end
                end else begin
                    count_nxt = count - PERIOD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count        <= BASE_LAST;
            level        <= '0;
            dir          <= 1'b1;
            just_dropped <= 1'b0;
            step         <= 1'b0;
            drop         <= 1'b0;
        end else begin
            count        <= count_nxt;
            level        <= level_nxt;
            dir          <= dir_nxt;
            just_dropped <= just_dropped_nxt;
            step         <= step_nxt;
            drop         <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_invader_step_scheduler.sv
// Scoreboard bench: stimulus queues expected step/drop pulses, a negedge monitor
// matches them against the DUT outputs.
module tb_invader_step_scheduler;

    logic       clk = 1'b0;
    logic       resetN, frame_tick, start, stop, pause, speed_up, edge_hit;
    logic       step, drop, dir, busy;
    logic [3:0] level;

    invader_step_scheduler dut (
        .clk(clk), .resetN(resetN), .frame_tick(frame_tick), .start(start),
        .stop(stop), .pause(pause), .speed_up(speed_up), .edge_hit(edge_hit),
        .step(step), .drop(drop), .dir(dir), .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_drop;
        bit dir;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock of stimulus; optionally queue the pulse this cycle must produce.
    task automatic cycle(input bit ft, input bit st, input bit sp, input bit su,
                         input bit exp_pulse, input bit is_drop, input bit d);
        exp_t e;
        frame_tick = ft; start = st; stop = sp; speed_up = su;
        if (exp_pulse) begin
            e.cyc = cyc + 1; e.is_drop = is_drop; e.dir = d;
            q.push_back(e);
        end
        @(posedge clk); #1;
        frame_tick = 1'b0; start = 1'b0; stop = 1'b0; speed_up = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step_tick(input bit d, input bit su);
        cycle(1, 0, 0, su, 1, 0, d);
    endtask

    task automatic drop_tick(input bit d);
        cycle(1, 0, 0, 0, 1, 1, d);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (step && drop) begin
            checks++; failures++;
            $display("FAIL step_drop_both actual=1 required=0 cyc=%0d", cyc);
        end
        if (step || drop) begin
            checks++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                failures++;
                $display("FAIL unexpected_pulse step=%0b drop=%0b cyc=%0d required=none", step, drop, cyc);
            end else begin
                e = q.pop_front();
                if (drop !== e.is_drop || dir !== e.dir) begin
                    failures++;
                    $display("FAIL pulse cyc=%0d actual drop=%0b dir=%0b required drop=%0b dir=%0b",
                             cyc, drop, dir, e.is_drop, e.dir);
                end
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++; failures++;
            $display("FAIL missing_pulse cyc=%0d actual=none required drop=%0b dir=%0b", e.cyc, e.is_drop, e.dir);
        end
    end

    initial begin
        resetN = 1'b0; frame_tick = 1'b0; start = 1'b0; stop = 1'b0;
        pause = 1'b0; speed_up = 1'b0; edge_hit = 1'b0;
        #12;
        chk("rst_step", step, 0);
        chk("rst_drop", drop, 0);
        chk("rst_dir", dir, 1);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        resetN = 1'b1;

        // Idle: ticks and speed_up do nothing before start
        ticks(100);
        cycle(0, 0, 0, 1, 0, 0, 0);
        chk("idle_dir", dir, 1);
        chk("idle_level", level, 0);
        chk("idle_busy", busy, 0);

        // Base period of 60 ticks
        cycle(0, 1, 0, 0, 0, 0, 0);
        chk("run_busy", busy, 1);
        ticks(59); step_tick(1, 0);
        ticks(59); step_tick(1, 0);

        // Speed-up mid-period: current period unchanged, next is 48
        ticks(20);
        repeat (3) cycle(0, 0, 0, 1, 0, 0, 0);
        chk("level3", level, 3);
        ticks(39); step_tick(1, 0);
        ticks(47); step_tick(1, 1);
        chk("level4", level, 4);
        ticks(47); step_tick(1, 0);
        ticks(43); step_tick(1, 0);

        // Saturation at 15 and the period floor of 2
        repeat (20) cycle(0, 0, 0, 1, 0, 0, 0);
        chk("level_sat", level, 15);
        ticks(43); step_tick(1, 0);
        ticks(1);  step_tick(1, 0);
        ticks(1);  step_tick(1, 1);
        chk("level_sat2", level, 15);

        // Edge handling: drop once per edge contact, then step
        edge_hit = 1'b1;
        ticks(1); drop_tick(0);
        chk("dir_after_drop", dir, 0);
        ticks(1); step_tick(0, 0);
        edge_hit = 1'b0;
        ticks(1); step_tick(0, 0);
        edge_hit = 1'b1;
        ticks(1); drop_tick(1);
        edge_hit = 1'b0;
        chk("dir_after_drop2", dir, 1);

        // Restart with coincident speed_up, then pause at count 20
        cycle(0, 1, 0, 1, 0, 0, 0);
        chk("restart_level", level, 0);
        ticks(39);
        pause = 1'b1;
        ticks(10);
        chk("paused_busy", busy, 1);
        pause = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 0);
        ticks(20); step_tick(1, 0);

        // Stop on an expiring tick: no pulse, back to idle
        ticks(59);
        cycle(1, 0, 1, 0, 0, 0, 0);
        chk("stop_busy", busy, 0);
        ticks(20);

        // Reset with a drop in flight
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        ticks(59);
        edge_hit = 1'b1; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        chk("inflight_drop", drop, 1);
        chk("inflight_dir", dir, 0);
        chk("inflight_level", level, 1);
        resetN = 1'b0;
        #1;
        chk("arst_drop", drop, 0);
        chk("arst_step", step, 0);
        chk("arst_dir", dir, 1);
        chk("arst_level", level, 0);
        chk("arst_busy", busy, 0);
        edge_hit = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b1;
        ticks(5);
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
